// File: rtl/mux_arbitro_rr.sv
// -----------------------------------------------------------------------------
// mux_arbitro_rr
//
// Round-robin arbiter and sequencer for the 2:1 memory mux datapath. Two
// requesters share one registered output. The block owns the mux select,
// issues registered grants with bursts of at most BURST beats while the other
// side is waiting, honours a downstream stall, and registers the winning data.
//
// Parameters:
//   DATA_W  width of each data input and of data_out
//   BURST   maximum consecutive beats for one requester under contention (>=1)
//   CNT_W   width of the per-requester beat counters (optional feature only)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_L    in   synchronous reset, active low
//   req0/req1  in   requester has a beat available on its data input
//   data_in0/1 in   requester data
//   stall      in   downstream cannot accept a beat this cycle
//   selector   out  current mux select (0 = data_in0, 1 = data_in1)
//   gnt0/gnt1  out  registered grants, never both high
//   data_out   out  registered winning data, held when no beat
//   valid_out  out  data_out carries a new beat this cycle
//   gnt_cnt0/1 out  beats delivered per requester, wrapping
//                   (present only when MUX_ARB_CNT_EN is defined)
//
// Optional feature macro: MUX_ARB_CNT_EN
// -----------------------------------------------------------------------------
module mux_arbitro_rr #(
    parameter int DATA_W = 2,
    parameter int BURST  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              stall,
    output logic              selector,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out
`ifdef MUX_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

    localparam int BCNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S0   = 2'd1,
        S1   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [BCNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic               last_served, last_served_nxt;
    logic               beat;
    logic [DATA_W-1:0]  beat_data;
    logic               last_beat;

    // The burst ends on the beat that brings the count up to BURST.
    assign last_beat = (beat_cnt == BCNT_W'(BURST - 1));

    // Grants decode straight from the state register, so they are registered.
    assign gnt0 = (state == S0);
    assign gnt1 = (state == S1);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt       = state;
        beat_cnt_nxt    = beat_cnt;
        last_served_nxt = last_served;
        beat            = 1'b0;
        beat_data       = data_in0;

        unique case (state)
            IDLE: begin
                // last_served == 1 means requester 0 wins the next tie.
                if (req0 && req1)  state_nxt = last_served ? S0 : S1;
                else if (req0)     state_nxt = S0;
                else if (req1)     state_nxt = S1;
            end

            S0: begin
                beat_data = data_in0;
                if (!stall) begin
                    if (!req0) begin
                        // Release: the cycle spent here is the dead cycle.
                        state_nxt       = req1 ? S1 : IDLE;
                        last_served_nxt = 1'b0;
                        beat_cnt_nxt    = '0;
                    end else begin
                        beat = 1'b1;
                        if (last_beat) begin
                            beat_cnt_nxt = '0;
                            if (req1) begin
                                state_nxt       = S1;
                                last_served_nxt = 1'b0;
                            end
                        end else begin
                            beat_cnt_nxt = beat_cnt + 1'b1;
                        end
                    end
                end
            end

            S1: begin
                beat_data = data_in1;
                if (!stall) begin
                    if (!req1) begin
                        state_nxt       = req0 ? S0 : IDLE;
                        last_served_nxt = 1'b1;
                        beat_cnt_nxt    = '0;
                    end else begin
                        beat = 1'b1;
                        if (last_beat) begin
                            beat_cnt_nxt = '0;
                            if (req0) begin
                                state_nxt       = S0;
                                last_served_nxt = 1'b1;
                            end
                        end else begin
                            beat_cnt_nxt = beat_cnt + 1'b1;
                        end
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            last_served <= 1'b1;
            selector    <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
        end else begin
            state       <= state_nxt;
            beat_cnt    <= beat_cnt_nxt;
            last_served <= last_served_nxt;
            valid_out   <= beat;
            if (beat) data_out <= beat_data;
            // selector follows the grant and holds its value through IDLE.
            if (state_nxt == S0)      selector <= 1'b0;
            else if (state_nxt == S1) selector <= 1'b1;
        end
    end

`ifdef MUX_ARB_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (beat) begin
            if (state == S0) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            else             gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_arbitro_rr.sv
// -----------------------------------------------------------------------------
// tb_mux_arbitro_rr
//
// Scoreboard bench for mux_arbitro_rr. A driver applies inputs on the falling
// edge, advances a behavioural model of the arbitration rules and queues the
// expected post-edge outputs. A monitor samples the DUT just after each rising
// edge and compares; beat data is also tracked in its own queue, popped
// whenever valid_out is seen.
// -----------------------------------------------------------------------------
module tb_mux_arbitro_rr;

    localparam int DATA_W = 2;
    localparam int BURST  = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b1;
    logic              reset_L = 1'b0;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic              stall = 1'b0;
    logic [DATA_W-1:0] data_in0 = '0;
    logic [DATA_W-1:0] data_in1 = '0;
    logic              selector;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
`ifdef MUX_ARB_CNT_EN
    logic [CNT_W-1:0]  gnt_cnt0;
    logic [CNT_W-1:0]  gnt_cnt1;
`endif

    mux_arbitro_rr #(.DATA_W(DATA_W), .BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .req0      (req0),
        .req1      (req1),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .stall     (stall),
        .selector  (selector),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .data_out  (data_out),
        .valid_out (valid_out)
`ifdef MUX_ARB_CNT_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              g0;
        logic              g1;
        logic              sel;
        logic              vld;
        logic [DATA_W-1:0] dout;
        logic [CNT_W-1:0]  c0;
        logic [CNT_W-1:0]  c1;
    } exp_t;

    exp_t              cyc_q[$];
    logic [DATA_W-1:0] data_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 nobody granted, else index of granted requester.
    // run: beats already delivered in the current burst.
    // prefer: who wins the next tie.
    int                owner  = -1;
    int                run    = 0;
    int                prefer = 0;
    logic              m_sel  = 1'b0;
    logic              m_vld  = 1'b0;
    logic [DATA_W-1:0] m_dout = '0;
    logic [CNT_W-1:0]  m_c0   = '0;
    logic [CNT_W-1:0]  m_c1   = '0;

    task automatic model_step(input logic r0, input logic r1, input logic st, input logic rst_n,
                              input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        logic              rq[2];
        logic [DATA_W-1:0] dd[2];
        int                other;
        rq[0] = r0; rq[1] = r1;
        dd[0] = d0; dd[1] = d1;
        if (!rst_n) begin
            owner = -1; run = 0; prefer = 0;
            m_sel = 1'b0; m_vld = 1'b0; m_dout = '0;
            m_c0 = '0; m_c1 = '0;
        end else begin
            m_vld = 1'b0;
            if (owner >= 0) begin
                if (rq[owner] && !st) m_vld = 1'b1;
            end
            if (m_vld) begin
                m_dout = dd[owner];
                data_q.push_back(dd[owner]);
                if (owner == 0) m_c0 = m_c0 + 1'b1;
                else            m_c1 = m_c1 + 1'b1;
            end
            if (owner < 0) begin
                if (rq[0] && rq[1]) owner = prefer;
                else if (rq[0])     owner = 0;
                else if (rq[1])     owner = 1;
            end else if (!st) begin
                other = 1 - owner;
                if (!rq[owner]) begin
                    prefer = other;
                    run    = 0;
                    owner  = rq[other] ? other : -1;
                end else begin
                    run++;
                    if (run == BURST) begin
                        run = 0;
                        if (rq[other]) begin
                            prefer = other;
                            owner  = other;
                        end
                    end
                end
            end
            if (owner >= 0) m_sel = (owner == 1);
        end
        cyc_q.push_back('{g0: (owner == 0), g1: (owner == 1), sel: m_sel, vld: m_vld,
                          dout: m_dout, c0: m_c0, c1: m_c1});
    endtask

    task automatic drive(input logic r0, input logic r1, input logic st, input logic rst_n,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        @(negedge clk);
        req0 = r0; req1 = r1; stall = st; reset_L = rst_n;
        data_in0 = d0; data_in1 = d1;
        model_step(r0, r1, st, rst_n, d0, d1);
    endtask

    function automatic logic pct(input int p);
        return ($urandom_range(0, 99) < p);
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t              e;
        logic [DATA_W-1:0] d;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cycle_queue: got empty expected entry at %0t", $time);
            end else begin
                e = cyc_q.pop_front();
                check("gnt0", 32'(gnt0), 32'(e.g0));
                check("gnt1", 32'(gnt1), 32'(e.g1));
                check("selector", 32'(selector), 32'(e.sel));
                check("valid_out", 32'(valid_out), 32'(e.vld));
                check("data_out", 32'(data_out), 32'(e.dout));
`ifdef MUX_ARB_CNT_EN
                check("gnt_cnt0", 32'(gnt_cnt0), 32'(e.c0));
                check("gnt_cnt1", 32'(gnt_cnt1), 32'(e.c1));
`endif
            end
            if (valid_out === 1'b1) begin
                if (data_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat_queue: got beat %0h expected no beat at %0t", data_out, $time);
                end else begin
                    d = data_q.pop_front();
                    check("beat_data", 32'(data_out), 32'(d));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset held for two edges with both requesting.
        repeat (2) drive(1, 1, 0, 0, 2'b01, 2'b10);
        // Contention with fixed data: 01 x4, 10 x4, ...
        repeat (24) drive(1, 1, 0, 1, 2'b01, 2'b10);
        // Contention with stalls.
        repeat (40) drive(1, 1, pct(30), 1, 2'b01, 2'b10);
        // Single requester 1, noise on the idle input.
        repeat (20) drive(0, 1, 0, 1, 2'($urandom), 2'b10);
        // Requester 0 drops out irregularly while requester 1 waits.
        repeat (40) drive(pct(60), 1, 0, 1, 2'b01, 2'b10);
        // Reset in the middle of a burst, then both request again.
        repeat (6) drive(1, 1, 0, 1, 2'b01, 2'b10);
        drive(1, 1, 0, 0, 2'b01, 2'b10);
        repeat (12) drive(1, 1, 0, 1, 2'b01, 2'b10);
        // Fresh reset, then a long single-requester run to wrap the counters.
        drive(0, 0, 0, 0, 2'b00, 2'b00);
        repeat (300) drive(1, 0, 0, 1, 2'($urandom), 2'($urandom));
        // Fully random traffic with occasional resets.
        repeat (1500) drive(pct(70), pct(70), pct(25), !pct(1), 2'($urandom), 2'($urandom));
        // Drain.
        repeat (3) drive(0, 0, 0, 1, 2'b00, 2'b00);
        @(posedge clk);
        #2;
        check("leftover_beats", 32'(data_q.size()), 32'd0);
        check("leftover_cycles", 32'(cyc_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
